// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  localparam int unsigned DMEM_AW = 32;
  localparam int unsigned DMEM_DW = 32;

  // Access size encodings carried on the low two bits of bs.
  typedef enum logic [1:0] {
    BS_NONE = 2'b00,
    BS_BYTE = 2'b01,
    BS_HALF = 2'b10,
    BS_WORD = 2'b11
  } bs_e;

  // Memory-mapped bases decoded downstream by data_mem.
  localparam logic [31:0] ID_BASE   = 32'h0010_0000;
  localparam logic [31:0] SW_BASE   = 32'h0010_0010;
  localparam logic [31:0] DMEM_BASE = 32'h8000_0000;

  // One requester's transaction fields.
  typedef struct packed {
    logic               we;
    logic [3:0]         bs;
    logic               se;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_align.sv
// Flags an access whose address is not naturally aligned for its size.
module align_check
  import dmem_pkg::*;
(
  input  logic [1:0] i_bs,
  input  logic [1:0] i_addr_lo,
  output logic       o_misaligned
);

  // Size-dependent alignment test; an empty size is never performed.
  always_comb begin
    o_misaligned = 1'b1;
    case (bs_e'(i_bs))
      BS_WORD: o_misaligned = |i_addr_lo;
      BS_HALF: o_misaligned = i_addr_lo[0];
      BS_BYTE: o_misaligned = 1'b0;
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data_mem: fixed priority to
// the load/store unit with a starvation guard for the debug/boot port,
// misalignment rejection, and a one-cycle tagged response pipeline.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [3:0]    req0_bs,
  input  logic          req0_se,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [3:0]    req1_bs,
  input  logic          req1_se,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,

  output logic          rsp_valid,
  output logic          rsp_id,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic          mem_se,
  output logic [3:0]    mem_bs,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_wait_cnt;
  logic          r_rsp_valid;
  logic          r_rsp_id;
  logic          r_rsp_err;
  logic          r_rsp_load;

  logic          w_starved;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_accept;
  logic          w_misaligned;
  logic          w_mem_ok;
  dmem_req_t     w_win;

  assign w_starved = (r_wait_cnt == CW'(MAX_WAIT));

  // Fixed priority to port 0 unless port 1 has waited MAX_WAIT cycles.
  always_comb begin
    w_grant1   = req1_valid && (!req0_valid || w_starved);
    w_grant0   = req0_valid && !w_grant1;
    w_accept   = w_grant0 || w_grant1;
    req0_ready = w_grant0;
    req1_ready = w_grant1;
  end

  // Select the winning request's fields.
  always_comb begin
    w_win = '0;
    if (w_grant1) begin
      w_win.we    = req1_we;
      w_win.bs    = req1_bs;
      w_win.se    = req1_se;
      w_win.addr  = req1_addr;
      w_win.wdata = req1_wdata;
    end else if (w_grant0) begin
      w_win.we    = req0_we;
      w_win.bs    = req0_bs;
      w_win.se    = req0_se;
      w_win.addr  = req0_addr;
      w_win.wdata = req0_wdata;
    end
  end

  align_check u_align (
    .i_bs         (w_win.bs[1:0]),
    .i_addr_lo    (w_win.addr[1:0]),
    .o_misaligned (w_misaligned)
  );

  assign w_mem_ok = w_accept && !w_misaligned;

  // Drive data_mem only for an aligned winner; idle values otherwise.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_se    = 1'b0;
    mem_bs    = 4'b0011;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_mem_ok) begin
      mem_en    = 1'b1;
      mem_we    = w_win.we;
      mem_se    = w_win.se;
      mem_bs    = w_win.bs;
      mem_addr  = w_win.addr;
      mem_wdata = w_win.wdata;
    end
  end

  // Starvation counter: counts refused port-1 cycles, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (req1_valid && !w_grant1) begin
      r_wait_cnt <= w_starved ? r_wait_cnt : r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Response pipeline aligned with data_mem's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_load  <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_id    <= w_grant1;
      r_rsp_err   <= w_accept && w_misaligned;
      r_rsp_load  <= w_mem_ok && !w_win.we;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_load ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural data_mem model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req0_ready, req0_we, req0_se;
  logic [3:0]  req0_bs;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_we, req1_se;
  logic [3:0]  req1_bs;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we, mem_se;
  logic [3:0]  mem_bs;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  dmem_arbiter #(.MAX_WAIT(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_bs(req0_bs), .req0_se(req0_se), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_bs(req1_bs), .req1_se(req1_se), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_se(mem_se), .mem_bs(mem_bs),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // data_mem model: synchronous read, write-first, sized and sign-extended.
  logic [31:0] mem [int unsigned];
  always @(posedge clk) begin : dmem_model
    logic [31:0] w;
    logic [31:0] r;
    int unsigned idx;
    if (mem_en) begin
      idx = {2'b00, mem_addr[31:2]};
      w = mem.exists(idx) ? mem[idx] : 32'h0;
      if (mem_we) begin
        case (mem_bs[1:0])
          2'b11: w = mem_wdata;
          2'b10: w[int'(mem_addr[1]) * 16 +: 16] = mem_wdata[15:0];
          default: w[int'(mem_addr[1:0]) * 8 +: 8] = mem_wdata[7:0];
        endcase
        mem[idx] = w;
      end
      case (mem_bs[1:0])
        2'b11: r = w;
        2'b10: begin
          r = {16'h0, w[int'(mem_addr[1]) * 16 +: 16]};
          if (mem_se && r[15]) r[31:16] = 16'hFFFF;
        end
        default: begin
          r = {24'h0, w[int'(mem_addr[1:0]) * 8 +: 8]};
          if (mem_se && r[7]) r[31:8] = 24'hFF_FFFF;
        end
      endcase
      mem_rdata <= r;
    end
  end

  typedef struct {
    logic        we;
    logic [3:0]  bs;
    logic        se;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rdata;
    int unsigned due;
  } exp_t;

  vec_t        q0[$];
  vec_t        q1[$];
  exp_t        sb[$];
  logic        grant_log[$];
  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] bs, input logic se,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata);
    vec_t v;
    v.we = we; v.bs = bs; v.se = se; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic drive(input int p, input vec_t v, input logic valid);
    if (p == 0) begin
      req0_valid = valid; req0_we = v.we; req0_bs = v.bs; req0_se = v.se;
      req0_addr = v.addr; req0_wdata = v.wdata;
    end else begin
      req1_valid = valid; req1_we = v.we; req1_bs = v.bs; req1_se = v.se;
      req1_addr = v.addr; req1_wdata = v.wdata;
    end
  endtask

  // Presents each queued request on port p and logs the expected response at accept.
  task automatic run_port(input int p);
    vec_t v;
    bit   got;
    forever begin
      if (p == 0) begin
        if (q0.size() == 0) break;
        v = q0.pop_front();
      end else begin
        if (q1.size() == 0) break;
        v = q1.pop_front();
      end
      drive(p, v, 1'b1);
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
        @(negedge clk);
        if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) got = 1'b1;
      end
      if (!got) begin
        n_vec++;
        n_mis++;
        $display("FAIL accept_timeout port%0d: got no ready expected ready within 50 cycles", p);
        break;
      end
      sb.push_back('{id: p[0], err: v.err, rdata: v.rdata, due: cyc + 1});
      grant_log.push_back(p[0]);
      check($sformatf("mem_en p%0d @%h", p, v.addr), {31'b0, mem_en}, {31'b0, !v.err});
      if (!v.err) check($sformatf("mem_we p%0d @%h", p, v.addr), {31'b0, mem_we}, {31'b0, v.we});
      @(posedge clk);
      #1;
    end
    drive(p, mk(0, 4'b0011, 0, 32'h0, 32'h0, 0, 32'h0), 1'b0);
  endtask

  task automatic run_phase();
    fork
      run_port(0);
      run_port(1);
    join
  endtask

  // Monitor: every response must match the oldest outstanding expectation in its cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && sb.size() != 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rsp_id",    {31'b0, rsp_id},    {31'b0, e.id});
        check("rsp_err",   {31'b0, rsp_err},   {31'b0, e.err});
        check("rsp_rdata", rsp_rdata,          e.rdata);
      end else if (rsp_valid) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 id=%0d expected no response (cycle %0d)",
                 rsp_id, cyc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got no finish expected completion before 200000 time units");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    exp_t     dropped;
    logic     exp_grants [11];
    vec_t     idle;
    idle = mk(0, 4'b0011, 0, 32'h0, 32'h0, 0, 32'h0);
    drive(0, idle, 1'b0);
    drive(1, idle, 1'b0);
    mem[32'h0010_0000 >> 2] = 32'h00D9_AC08;
    mem[32'h0010_0004 >> 2] = 32'h00A9_E27E;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst rsp_valid",  {31'b0, rsp_valid},  32'd0);
    check("rst rsp_rdata",  rsp_rdata,           32'd0);
    check("rst mem_en",     {31'b0, mem_en},     32'd0);
    check("rst mem_we",     {31'b0, mem_we},     32'd0);
    check("rst mem_bs",     {28'b0, mem_bs},     32'h3);
    check("rst req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst req1_ready", {31'b0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Port 0 word store then load back.
    q0.push_back(mk(1, 4'b0011, 0, 32'h8000_0000, 32'hAAAA_AAAA, 0, 32'h0));
    q0.push_back(mk(0, 4'b0011, 0, 32'h8000_0000, 32'h0,         0, 32'hAAAA_AAAA));
    run_phase();

    // Port 1 misaligned accesses, then a byte store.
    q1.push_back(mk(0, 4'b0010, 0, 32'h8000_0003, 32'h0,         1, 32'h0));
    q1.push_back(mk(0, 4'b0000, 0, 32'h8000_0000, 32'h0,         1, 32'h0));
    q1.push_back(mk(1, 4'b0011, 0, 32'h8000_0002, 32'h5555_5555, 1, 32'h0));
    q1.push_back(mk(1, 4'b0001, 0, 32'h8000_0004, 32'h0000_00F0, 0, 32'h0));
    run_phase();

    // Port 0 loads right behind the port-1 store, sized and sign-extended, plus ID regs.
    q0.push_back(mk(0, 4'b0001, 1, 32'h8000_0004, 32'h0, 0, 32'hFFFF_FFF0));
    q0.push_back(mk(0, 4'b0001, 0, 32'h8000_0004, 32'h0, 0, 32'h0000_00F0));
    q0.push_back(mk(0, 4'b0011, 0, 32'h0010_0000, 32'h0, 0, 32'h00D9_AC08));
    q0.push_back(mk(0, 4'b0011, 0, 32'h0010_0004, 32'h0, 0, 32'h00A9_E27E));
    q0.push_back(mk(0, 4'b0010, 0, 32'h8000_0002, 32'h0, 0, 32'h0000_AAAA));
    q0.push_back(mk(0, 4'b0010, 1, 32'h8000_0002, 32'h0, 0, 32'hFFFF_AAAA));
    q0.push_back(mk(0, 4'b0001, 1, 32'h8000_0001, 32'h0, 0, 32'hFFFF_FFAA));
    q0.push_back(mk(0, 4'b0011, 0, 32'h8000_0000, 32'h0, 0, 32'hAAAA_AAAA));
    q0.push_back(mk(0, 4'b1111, 0, 32'h8000_0004, 32'h0, 0, 32'h0000_00F0));
    run_phase();

    // Reset in the cycle after an accept: the in-flight response is discarded.
    drive(0, mk(0, 4'b0011, 0, 32'h8000_0000, 32'h0, 0, 32'h0), 1'b1);
    drive(1, mk(0, 4'b0011, 0, 32'h8000_0000, 32'h0, 0, 32'h0), 1'b1);
    @(negedge clk);
    check("rstmid req0_ready", {31'b0, req0_ready}, 32'd1);
    sb.push_back('{id: 1'b0, err: 1'b0, rdata: 32'hAAAA_AAAA, due: cyc + 1});
    @(posedge clk); #1;
    check("rstmid pre rsp_valid", {31'b0, rsp_valid}, 32'd1);
    dropped = sb.pop_front();
    rst = 1'b1;
    drive(0, idle, 1'b0);
    drive(1, idle, 1'b0);
    #1;
    check("rstmid rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rstmid rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Both ports valid continuously: four port-0 wins, then port 1 forced.
    grant_log.delete();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) q0.push_back(mk(0, 4'b0011, 0, 32'h8000_0000, 32'h0, 0, 32'hAAAA_AAAA));
      else            q0.push_back(mk(0, 4'b0011, 0, 32'h0010_0000, 32'h0, 0, 32'h00D9_AC08));
    end
    q1.push_back(mk(1, 4'b0011, 0, 32'h8000_0010, 32'h1111_1111, 0, 32'h0));
    q1.push_back(mk(1, 4'b0011, 0, 32'h8000_0014, 32'h2222_2222, 0, 32'h0));
    q1.push_back(mk(1, 4'b0011, 0, 32'h8000_0018, 32'h3333_3333, 0, 32'h0));
    run_phase();
    exp_grants = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
    check("grant count", grant_log.size(), 32'd11);
    for (int i = 0; i < 11 && i < grant_log.size(); i++)
      check($sformatf("grant[%0d]", i), {31'b0, grant_log[i]}, {31'b0, exp_grants[i]});

    // Idle cycles: nothing further may appear and nothing may remain outstanding.
    repeat (3) @(negedge clk);
    check("idle mem_en", {31'b0, mem_en}, 32'd0);
    check("sb drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
